// File: rtl/nasti_mux_n_if.sv
// NASTI channel bundle: every field is a packed array of N_LANES entries so one
// interface instance can carry either a single port or a group of upstream lanes.
interface nasti_channel #(
  parameter int N_LANES    = 1,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [N_LANES-1:0][ID_WIDTH-1:0]     aw_id;
  logic [N_LANES-1:0][ADDR_WIDTH-1:0]   aw_addr;
  logic [N_LANES-1:0][7:0]              aw_len;
  logic [N_LANES-1:0][2:0]              aw_size;
  logic [N_LANES-1:0][1:0]              aw_burst;
  logic [N_LANES-1:0]                   aw_lock;
  logic [N_LANES-1:0][3:0]              aw_cache;
  logic [N_LANES-1:0][2:0]              aw_prot;
  logic [N_LANES-1:0][3:0]              aw_qos;
  logic [N_LANES-1:0][USER_WIDTH-1:0]   aw_user;
  logic [N_LANES-1:0]                   aw_valid;
  logic [N_LANES-1:0]                   aw_ready;

  logic [N_LANES-1:0][ID_WIDTH-1:0]     ar_id;
  logic [N_LANES-1:0][ADDR_WIDTH-1:0]   ar_addr;
  logic [N_LANES-1:0][7:0]              ar_len;
  logic [N_LANES-1:0][2:0]              ar_size;
  logic [N_LANES-1:0][1:0]              ar_burst;
  logic [N_LANES-1:0]                   ar_lock;
  logic [N_LANES-1:0][3:0]              ar_cache;
  logic [N_LANES-1:0][2:0]              ar_prot;
  logic [N_LANES-1:0][3:0]              ar_qos;
  logic [N_LANES-1:0][USER_WIDTH-1:0]   ar_user;
  logic [N_LANES-1:0]                   ar_valid;
  logic [N_LANES-1:0]                   ar_ready;

  logic [N_LANES-1:0][DATA_WIDTH-1:0]   w_data;
  logic [N_LANES-1:0][DATA_WIDTH/8-1:0] w_strb;
  logic [N_LANES-1:0]                   w_last;
  logic [N_LANES-1:0][USER_WIDTH-1:0]   w_user;
  logic [N_LANES-1:0]                   w_valid;
  logic [N_LANES-1:0]                   w_ready;

  logic [N_LANES-1:0][ID_WIDTH-1:0]     b_id;
  logic [N_LANES-1:0][1:0]              b_resp;
  logic [N_LANES-1:0][USER_WIDTH-1:0]   b_user;
  logic [N_LANES-1:0]                   b_valid;
  logic [N_LANES-1:0]                   b_ready;

  logic [N_LANES-1:0][ID_WIDTH-1:0]     r_id;
  logic [N_LANES-1:0][DATA_WIDTH-1:0]   r_data;
  logic [N_LANES-1:0][1:0]              r_resp;
  logic [N_LANES-1:0]                   r_last;
  logic [N_LANES-1:0][USER_WIDTH-1:0]   r_user;
  logic [N_LANES-1:0]                   r_valid;
  logic [N_LANES-1:0]                   r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_user, ar_valid,
    output ar_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_mux_n.sv
// N-to-1 NASTI multiplexer: round-robin AW/AR arbitration, W steered by an order
// FIFO of granted AW lanes, B/R steered back by ID through outstanding tables.
module nasti_mux_n #(
  parameter int N_PORT        = 4,
  parameter int W_MAX         = 4,
  parameter int R_MAX         = 4,
  parameter int W_ORDER_DEPTH = 4,
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int USER_WIDTH    = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  nasti_channel.slave              s,
  nasti_channel.master             m,
  output logic [$clog2(W_MAX):0]   w_outstanding,
  output logic [$clog2(R_MAX):0]   r_outstanding
);
  localparam int NL = 8;
  localparam int WS = $clog2(W_MAX);
  localparam int RS = $clog2(R_MAX);
  localparam int OW = (W_ORDER_DEPTH > 1) ? $clog2(W_ORDER_DEPTH) : 1;
  localparam logic [OW:0] ORD_FULL = (OW + 1)'(W_ORDER_DEPTH);

  typedef logic [2:0] lane_t;

  // Search starts at ptr (the lane after the last grant); nearest eligible lane wins.
  function automatic logic [3:0] rr_pick(input logic [NL-1:0] elig, input lane_t ptr);
    logic [3:0] res;
    int idx;
    res = '0;
    for (int k = N_PORT - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORT) idx -= N_PORT;
      if (elig[idx]) res = {1'b1, lane_t'(idx)};
    end
    return res;
  endfunction

  function automatic lane_t rr_next(input lane_t l);
    if (int'(l) + 1 >= N_PORT) return '0;
    return l + 3'd1;
  endfunction

  logic [W_MAX-1:0]    wv_q, wv_d;
  logic [ID_WIDTH-1:0] wid_q [W_MAX];
  logic [ID_WIDTH-1:0] wid_d [W_MAX];
  lane_t               wport_q [W_MAX];
  lane_t               wport_d [W_MAX];
  logic [R_MAX-1:0]    rv_q, rv_d;
  logic [ID_WIDTH-1:0] rid_q [R_MAX];
  logic [ID_WIDTH-1:0] rid_d [R_MAX];
  lane_t               rport_q [R_MAX];
  lane_t               rport_d [R_MAX];
  lane_t               ord_q [W_ORDER_DEPTH];
  lane_t               ord_d [W_ORDER_DEPTH];
  logic [OW-1:0]       ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
  logic [OW:0]         ord_cnt_q, ord_cnt_d;
  lane_t               aw_ptr_q, aw_ptr_d, ar_ptr_q, ar_ptr_d;
  logic                aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
  lane_t               aw_hsel_q, aw_hsel_d, ar_hsel_q, ar_hsel_d;

  logic [NL-1:0] aw_elig, ar_elig;
  logic          aw_found, ar_found, aw_go, ar_go, aw_hs, ar_hs;
  lane_t         aw_sel, ar_sel, ord_head, b_port, r_port;
  logic [WS-1:0] w_free, b_slot;
  logic [RS-1:0] r_free, r_slot;
  logic          ord_empty, w_pop, b_hit, r_hit, b_free, r_free_en;
  logic [NL-1:0] s_aw_ready, s_ar_ready, s_w_ready, s_b_valid, s_r_valid;

  // A lane whose ID is already outstanding from another lane is held off so that
  // responses can never be routed to the wrong master.
  always_comb begin
    aw_elig = '0;
    ar_elig = '0;
    for (int i = 0; i < N_PORT; i++) begin
      aw_elig[i] = s.aw_valid[i];
      ar_elig[i] = s.ar_valid[i];
      for (int j = 0; j < W_MAX; j++)
        if (wv_q[j] && wid_q[j] == s.aw_id[i] && wport_q[j] != lane_t'(i)) aw_elig[i] = 1'b0;
      for (int j = 0; j < R_MAX; j++)
        if (rv_q[j] && rid_q[j] == s.ar_id[i] && rport_q[j] != lane_t'(i)) ar_elig[i] = 1'b0;
    end
    {aw_found, aw_sel} = rr_pick(aw_elig, aw_ptr_q);
    {ar_found, ar_sel} = rr_pick(ar_elig, ar_ptr_q);
    if (aw_hold_q) begin
      aw_sel   = aw_hsel_q;
      aw_found = s.aw_valid[aw_hsel_q];
    end
    if (ar_hold_q) begin
      ar_sel   = ar_hsel_q;
      ar_found = s.ar_valid[ar_hsel_q];
    end
    aw_go = rstn && aw_found && !(&wv_q) && (ord_cnt_q != ORD_FULL);
    ar_go = rstn && ar_found && !(&rv_q);
    aw_hs = aw_go && m.aw_ready[0];
    ar_hs = ar_go && m.ar_ready[0];
  end

  always_comb begin
    w_free = '0;
    r_free = '0;
    for (int j = W_MAX - 1; j >= 0; j--) if (!wv_q[j]) w_free = WS'(j);
    for (int j = R_MAX - 1; j >= 0; j--) if (!rv_q[j]) r_free = RS'(j);
  end

  assign m.aw_valid  = aw_go;
  assign m.aw_id     = s.aw_id[aw_sel];
  assign m.aw_addr   = s.aw_addr[aw_sel];
  assign m.aw_len    = s.aw_len[aw_sel];
  assign m.aw_size   = s.aw_size[aw_sel];
  assign m.aw_burst  = s.aw_burst[aw_sel];
  assign m.aw_lock   = s.aw_lock[aw_sel];
  assign m.aw_cache  = s.aw_cache[aw_sel];
  assign m.aw_prot   = s.aw_prot[aw_sel];
  assign m.aw_qos    = s.aw_qos[aw_sel];
  assign m.aw_user   = s.aw_user[aw_sel];
  assign m.ar_valid  = ar_go;
  assign m.ar_id     = s.ar_id[ar_sel];
  assign m.ar_addr   = s.ar_addr[ar_sel];
  assign m.ar_len    = s.ar_len[ar_sel];
  assign m.ar_size   = s.ar_size[ar_sel];
  assign m.ar_burst  = s.ar_burst[ar_sel];
  assign m.ar_lock   = s.ar_lock[ar_sel];
  assign m.ar_cache  = s.ar_cache[ar_sel];
  assign m.ar_prot   = s.ar_prot[ar_sel];
  assign m.ar_qos    = s.ar_qos[ar_sel];
  assign m.ar_user   = s.ar_user[ar_sel];

  // W follows the lane at the head of the order FIFO.
  assign ord_head  = ord_q[ord_rd_q];
  assign ord_empty = (ord_cnt_q == '0);
  assign m.w_valid = !ord_empty && s.w_valid[ord_head];
  assign m.w_data  = s.w_data[ord_head];
  assign m.w_strb  = s.w_strb[ord_head];
  assign m.w_last  = s.w_last[ord_head];
  assign m.w_user  = s.w_user[ord_head];
  assign w_pop     = m.w_valid[0] && m.w_ready[0] && m.w_last[0];

  // Lowest-index match keeps stacked same-ID entries in issue order.
  always_comb begin
    b_hit  = 1'b0;
    b_slot = '0;
    r_hit  = 1'b0;
    r_slot = '0;
    for (int j = W_MAX - 1; j >= 0; j--)
      if (wv_q[j] && wid_q[j] == m.b_id[0]) begin
        b_hit  = 1'b1;
        b_slot = WS'(j);
      end
    for (int j = R_MAX - 1; j >= 0; j--)
      if (rv_q[j] && rid_q[j] == m.r_id[0]) begin
        r_hit  = 1'b1;
        r_slot = RS'(j);
      end
    b_port = wport_q[b_slot];
    r_port = rport_q[r_slot];
  end

  assign m.b_ready = b_hit ? s.b_ready[b_port] : 1'b1;
  assign m.r_ready = r_hit ? s.r_ready[r_port] : 1'b1;
  assign b_free    = b_hit && m.b_valid[0] && m.b_ready[0];
  assign r_free_en = r_hit && m.r_valid[0] && m.r_ready[0] && m.r_last[0];

  always_comb begin
    s_aw_ready = '0;
    s_ar_ready = '0;
    s_w_ready  = '0;
    s_b_valid  = '0;
    s_r_valid  = '0;
    if (aw_go) s_aw_ready[aw_sel] = m.aw_ready[0];
    if (ar_go) s_ar_ready[ar_sel] = m.ar_ready[0];
    if (!ord_empty) s_w_ready[ord_head] = m.w_ready[0];
    if (b_hit) s_b_valid[b_port] = m.b_valid[0];
    if (r_hit) s_r_valid[r_port] = m.r_valid[0];
  end

  assign s.aw_ready = s_aw_ready;
  assign s.ar_ready = s_ar_ready;
  assign s.w_ready  = s_w_ready;
  assign s.b_valid  = s_b_valid;
  assign s.r_valid  = s_r_valid;
  assign s.b_id     = {NL{m.b_id[0]}};
  assign s.b_resp   = {NL{m.b_resp[0]}};
  assign s.b_user   = {NL{m.b_user[0]}};
  assign s.r_id     = {NL{m.r_id[0]}};
  assign s.r_data   = {NL{m.r_data[0]}};
  assign s.r_resp   = {NL{m.r_resp[0]}};
  assign s.r_last   = {NL{m.r_last[0]}};
  assign s.r_user   = {NL{m.r_user[0]}};

  // Allocation only targets slots free in the current state, so a slot freed
  // this cycle never collides with a new entry.
  always_comb begin
    wv_d    = wv_q;
    wid_d   = wid_q;
    wport_d = wport_q;
    rv_d    = rv_q;
    rid_d   = rid_q;
    rport_d = rport_q;
    if (b_free) wv_d[b_slot] = 1'b0;
    if (aw_hs) begin
      wv_d[w_free]    = 1'b1;
      wid_d[w_free]   = m.aw_id[0];
      wport_d[w_free] = aw_sel;
    end
    if (r_free_en) rv_d[r_slot] = 1'b0;
    if (ar_hs) begin
      rv_d[r_free]    = 1'b1;
      rid_d[r_free]   = m.ar_id[0];
      rport_d[r_free] = ar_sel;
    end
  end

  always_comb begin
    ord_d     = ord_q;
    ord_wr_d  = ord_wr_q;
    ord_rd_d  = ord_rd_q;
    ord_cnt_d = ord_cnt_q + (OW + 1)'(aw_hs) - (OW + 1)'(w_pop);
    if (aw_hs) begin
      ord_d[ord_wr_q] = aw_sel;
      ord_wr_d        = ord_wr_q + 1'b1;
    end
    if (w_pop) ord_rd_d = ord_rd_q + 1'b1;
    aw_ptr_d  = aw_hs ? rr_next(aw_sel) : aw_ptr_q;
    ar_ptr_d  = ar_hs ? rr_next(ar_sel) : ar_ptr_q;
    aw_hold_d = aw_go && !m.aw_ready[0];
    ar_hold_d = ar_go && !m.ar_ready[0];
    aw_hsel_d = aw_sel;
    ar_hsel_d = ar_sel;
  end

  always_comb begin
    w_outstanding = '0;
    r_outstanding = '0;
    for (int j = 0; j < W_MAX; j++) w_outstanding += (WS + 1)'(wv_q[j]);
    for (int j = 0; j < R_MAX; j++) r_outstanding += (RS + 1)'(rv_q[j]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wv_q      <= '0;
      rv_q      <= '0;
      ord_wr_q  <= '0;
      ord_rd_q  <= '0;
      ord_cnt_q <= '0;
      aw_ptr_q  <= '0;
      ar_ptr_q  <= '0;
      aw_hold_q <= 1'b0;
      ar_hold_q <= 1'b0;
      aw_hsel_q <= '0;
      ar_hsel_q <= '0;
      for (int j = 0; j < W_MAX; j++) begin
        wid_q[j]   <= '0;
        wport_q[j] <= '0;
      end
      for (int j = 0; j < R_MAX; j++) begin
        rid_q[j]   <= '0;
        rport_q[j] <= '0;
      end
      for (int j = 0; j < W_ORDER_DEPTH; j++) ord_q[j] <= '0;
    end else begin
      wv_q      <= wv_d;
      wid_q     <= wid_d;
      wport_q   <= wport_d;
      rv_q      <= rv_d;
      rid_q     <= rid_d;
      rport_q   <= rport_d;
      ord_q     <= ord_d;
      ord_wr_q  <= ord_wr_d;
      ord_rd_q  <= ord_rd_d;
      ord_cnt_q <= ord_cnt_d;
      aw_ptr_q  <= aw_ptr_d;
      ar_ptr_q  <= ar_ptr_d;
      aw_hold_q <= aw_hold_d;
      ar_hold_q <= ar_hold_d;
      aw_hsel_q <= aw_hsel_d;
      ar_hsel_q <= ar_hsel_d;
    end
  end
endmodule

// File: doc/nasti_mux_n.md
Name: nasti_mux_n

Overview:
- N-to-1 NASTI multiplexer that merges up to 8 upstream masters onto one downstream NASTI port.
- Sits between CPU/DMA masters and a shared memory/peripheral crossbar leg.
- Separate round-robin arbitration for AW and AR; W data follows granted AW order through an order FIFO; B/R responses are routed back by ID using outstanding-transaction tables.
- Same-ID hazards across ports stall arbitration rather than misroute.

Parameters:
- N_PORT, 4, number of slave lanes used (1..8); lanes >= N_PORT are ignored and driven ready=0, valid=0.
- W_MAX, 4, maximum outstanding write transactions (power of 2, >= 2).
- R_MAX, 4, maximum outstanding read transactions (power of 2, >= 2).
- W_ORDER_DEPTH, 4, depth of the W-order FIFO (power of 2).
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width.
- USER_WIDTH, 1, user field width (>= 1).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- s  nasti_channel.slave  8 lanes x NASTI fields  upstream masters; lane i uses index [i] of every field.
- m  nasti_channel.master  1 lane  downstream port.
- w_outstanding  output  $clog2(W_MAX)+1  number of valid write table entries.
- r_outstanding  output  $clog2(R_MAX)+1  number of valid read table entries.

Behaviour:
- Reset (rstn=0, asynchronous):
  - Both tables are cleared and the order FIFO is emptied.
  - Arbiter pointers return to lane 0.
  - All m.*_valid, s.*_ready, s.b_valid and s.r_valid are 0; counters are 0.
  - A reset mid-burst drops all in-flight state without completing the burst.
- AW arbitration:
  - Round-robin among s.aw_valid[i], i < N_PORT, starting after the last granted lane.
  - The grant is held while m.aw_valid=1 and m.aw_ready=0; AW payload must stay stable.
  - m.aw_valid=0 while any of these holds:
    - the write table is full;
    - the order FIFO is full;
    - the write table holds a valid entry with the same aw_id from a different lane (that lane is skipped this cycle).
  - On an AW handshake:
    - a write entry {id, port} is allocated in the lowest free slot;
    - the port is pushed into the order FIFO;
    - the pointer advances.
- W routing:
  - The FIFO head selects the source lane; m.w_* = s.w_*[head] and s.w_ready[head] = m.w_ready.
  - All other lanes get w_ready=0.
  - The head is popped on a W handshake with w_last.
  - FIFO empty: m.w_valid=0. W never precedes its AW.
  - W of burst k+1 may start the cycle after w_last of burst k.
  - The next AW may be accepted while W of an earlier burst is in progress.
- B routing:
  - The matching write entry is the lowest-index valid entry whose id equals m.b_id.
  - s.b_valid[port] = m.b_valid; s.b_id, s.b_resp and s.b_user are broadcast to all lanes; m.b_ready = s.b_ready[port].
  - No match: m.b_ready=1 and the B beat is silently dropped (protocol error).
  - The matched entry is freed on a B handshake.
- AR arbitration: independent round-robin with the same rules against the read table (full, cross-lane same-ID stall). AR handshake allocates a read entry.
- R routing:
  - Matching by m.r_id as for B; r_data, r_id, r_resp, r_last and r_user are broadcast; valid and ready are steered to the matched lane.
  - The entry is freed only on a handshake with r_last=1.
- Simultaneous events:
  - Allocate and free in the same cycle are both honoured.
  - A slot freed this cycle is not reused until the next cycle.
  - The counters reflect the net change.
- Same-ID / same-lane transactions may stack (multiple entries); responses retire the lowest index first, matching AXI same-ID ordering.
- Latency: zero-cycle combinational pass-through on all channels; only the arbiter pointer, tables and FIFO are registered.

Test Plan:
1. Lanes 0,1,2 assert AR simultaneously (ids 1,2,3), m.ar_ready=1 → grants in order 0,1,2 on consecutive cycles; R with r_id=2, r_last=1 → s.r_valid[1] only; r_outstanding goes 3→2.
2. Lane 0 issues AW (len=3), then lane 3 issues AW (len=0) before lane 0's W completes → m.w carries 4 beats from lane 0, then 1 beat from lane 3; the order FIFO empties.
3. Fill the write table with W_MAX=4 AWs and hold m.b_valid=0 → the 5th AW sees m.aw_valid=0 and s.aw_ready=0 until a B handshake; the next cycle it is accepted.
4. Lane 1 has read id=5 outstanding and lane 2 requests AR id=5 while lane 0 requests AR id=6 → lane 0 is granted and lane 2 stalls until lane 1's r_last handshake.
5. B beat with an unmatched id=7 → m.b_ready=1, all s.b_valid=0, tables unchanged.
6. Assert rstn=0 mid-W-burst (beat 2 of 4) → all valids/readies are 0 asynchronously; after release, w_outstanding=0 and a fresh AW from lane 0 is granted first.
